// File: rtl/if_stage_prefetch_if.sv
// Bundle of the fetch stage's external traffic: instruction SRAM read port,
// branch redirect input, and the IF->ID valid/allowin handshake.
interface if_stage_prefetch_if;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  modport master (
    output inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst,
    input  inst_sram_rdata, br_valid, br_target, id_allowin
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst,
    output inst_sram_rdata, br_valid, br_target, id_allowin
  );
endinterface

// File: rtl/if_stage_prefetch.sv
// Fetch stage: owns the PC, issues one SRAM read per cycle and buffers the
// returned words in a small FIFO presented to ID; branch redirects flush it.
module if_stage_prefetch #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_prefetch_if.master bus
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(IBUF_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IBUF_DEPTH);

  logic [31:0]      pc;
  logic [31:0]      req_pc;
  logic             inflight;
  logic             drop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [31:0] pc_mem   [IBUF_DEPTH];
  logic [31:0] inst_mem [IBUF_DEPTH];

  logic             head_valid;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic             unused_br_low;

  assign unused_br_low = ^bus.br_target[1:0];

  // Occupancy counts the outstanding read too, so a full FIFO can never be
  // overrun by a response; a same-cycle pop is deliberately not credited.
  assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign head_valid = (count != '0);
  assign issue      = ~reset & ~bus.br_valid & (occupancy < DEPTH_OCC);
  assign push       = inflight & ~drop & ~bus.br_valid;
  assign pop        = head_valid & bus.id_allowin & ~bus.br_valid;

  assign bus.inst_sram_en   = issue;
  assign bus.inst_sram_addr = pc;
  assign bus.if_valid       = head_valid;
  assign bus.if_pc          = head_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign bus.if_inst        = head_valid ? inst_mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (bus.br_valid) begin
      // Redirect wins over everything: the outstanding read is marked stale.
      pc       <= {bus.br_target[31:2], 2'b00};
      inflight <= 1'b0;
      drop     <= inflight;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      inflight <= issue;
      drop     <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= bus.inst_sram_rdata;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && count == DEPTH_CNT));

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Self-checking bench for if_stage_prefetch: directed scenarios plus random
// allowin/redirect traffic compared against a queue-based fetch model.
module tb_if_stage_prefetch;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] SALT     = 32'hA5A5A5A5;

  logic clk;
  logic reset;
  logic [31:0] sram_rdata;

  if_stage_prefetch_if bus ();

  if_stage_prefetch #(
    .RESET_PC   (RESET_PC),
    .IBUF_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests;
  int failed;

  // Reference model: fetch PC, buffered {pc, inst} entries and one pending read.
  logic [63:0] q [$];
  logic [31:0] m_pc;
  logic [31:0] pend_pc;
  bit          pend_v;
  bit          pend_drop;
  bit          exp_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM returns addr^SALT one cycle after a read; garbage otherwise.
  assign bus.inst_sram_rdata = sram_rdata;
  always @(posedge clk) begin
    if (bus.inst_sram_en) sram_rdata <= bus.inst_sram_addr ^ SALT;
    else                  sram_rdata <= $urandom;
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_pc      = RESET_PC;
    pend_v    = 0;
    pend_drop = 0;
    pend_pc   = 32'h0;
  endtask

  task automatic checkOutput();
    exp_en = !bus.br_valid && (q.size() + int'(pend_v) < DEPTH);
    compare("en",    {31'b0, bus.inst_sram_en}, {31'b0, exp_en});
    compare("addr",  bus.inst_sram_addr, m_pc);
    compare("valid", {31'b0, bus.if_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      compare("if_pc",   bus.if_pc,   q[0][63:32]);
      compare("if_inst", bus.if_inst, q[0][31:0]);
    end
  endtask

  task automatic modelUpdate(input bit br, input logic [31:0] tgt, input bit allow);
    if (br) begin
      m_pc      = {tgt[31:2], 2'b00};
      q.delete();
      pend_drop = pend_v;
      pend_v    = 0;
    end else begin
      if (allow && q.size() != 0) void'(q.pop_front());
      if (pend_v && !pend_drop) q.push_back({pend_pc, pend_pc ^ SALT});
      pend_drop = 0;
      if (exp_en) begin
        pend_v  = 1;
        pend_pc = m_pc;
        m_pc    = m_pc + 32'd4;
      end else begin
        pend_v = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit br, input logic [31:0] tgt, input bit allow);
    @(negedge clk);
    bus.br_valid   = br;
    bus.br_target  = tgt;
    bus.id_allowin = allow;
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate(br, tgt, allow);
    #1;
    bus.br_valid = 1'b0;
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.br_valid   = 1'b0;
    bus.br_target  = 32'h0;
    bus.id_allowin = 1'b0;
    @(negedge clk);
    #1;
    compare("rst_en",    {31'b0, bus.inst_sram_en}, 32'h0);
    compare("rst_valid", {31'b0, bus.if_valid},     32'h0);
    compare("rst_pc",    bus.if_pc,   32'h0);
    compare("rst_inst",  bus.if_inst, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    sram_rdata = 32'h0;
    modelReset();

    // Streaming from reset with ID always ready.
    doReset();
    repeat (2) applyStimulus(0, 32'h0, 1);
    #1;
    compare("t1_first_valid", {31'b0, bus.if_valid}, 32'h1);
    compare("t1_first_pc",    bus.if_pc,   32'h1c000000);
    compare("t1_first_inst",  bus.if_inst, 32'h1c000000 ^ SALT);
    repeat (12) applyStimulus(0, 32'h0, 1);

    // ID stalled: exactly four entries, issue stops, head held.
    doReset();
    repeat (8) applyStimulus(0, 32'h0, 0);
    #1;
    compare("t2_en_stalled", {31'b0, bus.inst_sram_en}, 32'h0);
    compare("t2_head_pc",    bus.if_pc, 32'h1c000000);
    repeat (10) applyStimulus(0, 32'h0, 1);

    // Redirect while one read is in flight and two entries are buffered.
    doReset();
    repeat (3) applyStimulus(0, 32'h0, 0);
    applyStimulus(1, 32'h1c000100, 0);
    applyStimulus(0, 32'h0, 1);
    applyStimulus(0, 32'h0, 1);
    #1;
    compare("t3_valid_after", {31'b0, bus.if_valid}, 32'h1);
    compare("t3_pc_after",    bus.if_pc, 32'h1c000100);
    repeat (4) applyStimulus(0, 32'h0, 1);

    // Unaligned target is word-aligned.
    applyStimulus(1, 32'h1c000102, 1);
    #1;
    compare("t4_addr", bus.inst_sram_addr, 32'h1c000100);
    repeat (4) applyStimulus(0, 32'h0, 1);

    // Back-to-back redirects: only the last survives.
    applyStimulus(1, 32'h1c000200, 1);
    applyStimulus(1, 32'h1c000300, 1);
    applyStimulus(0, 32'h0, 1);
    applyStimulus(0, 32'h0, 1);
    #1;
    compare("t5_pc_after", bus.if_pc, 32'h1c000300);
    repeat (4) applyStimulus(0, 32'h0, 1);

    // PC wraps at the top of the address space.
    applyStimulus(1, 32'hFFFFFFF8, 1);
    repeat (6) applyStimulus(0, 32'h0, 1);

    // Async reset mid-stream, away from a clock edge.
    repeat (3) applyStimulus(0, 32'h0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    compare("t6_en_async",    {31'b0, bus.inst_sram_en}, 32'h0);
    compare("t6_valid_async", {31'b0, bus.if_valid},     32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    repeat (6) applyStimulus(0, 32'h0, 1);

    // Random allowin and occasional redirects.
    for (int i = 0; i < 400; i++) begin
      bit          br;
      bit          allow;
      logic [31:0] tgt;
      br    = ($urandom_range(0, 15) == 0);
      allow = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tgt   = 32'h1c000000 + 32'($urandom_range(0, 4095));
      applyStimulus(br, tgt, allow);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
